// File: rtl/bit_capture_buffer_pkg.sv
// Shared defaults and helpers for the serial bit capture buffer.
package bit_capture_buffer_pkg;

  localparam int unsigned WORD_W_DEF      = 8;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam bit          SAMPLE_FALL_DEF = 1'b1;
  localparam logic [7:0]  MATCH_WORD_DEF  = 8'hAA;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bit_capture_buffer_if.sv
// Valid/ready word stream from the capture buffer to its consumer.
interface bit_capture_buffer_if
  import bit_capture_buffer_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/bit_capture_buffer_fifo.sv
// First-word-fall-through word FIFO with registered head, explicit level and flush.
module bit_capture_buffer_fifo
  import bit_capture_buffer_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [WORD_W-1:0]                push_data,
  input  logic                             pop,
  input  logic                             flush,
  output logic [WORD_W-1:0]                head_data,
  output logic                             head_valid,
  output logic                             full_c,
  output logic [$clog2(DEPTH+1)-1:0]       level
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = level_w(DEPTH);

  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [WORD_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [WORD_W-1:0]  head_q, head_d;
  logic               valid_q, valid_d;
  logic               do_push, do_pop;

  assign full_c  = (level_q == LEVEL_W'(DEPTH));
  assign do_pop  = pop & valid_q;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push & (~full_c | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    valid_d  = valid_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LEVEL_W'(1);
        2'b01:   level_d = level_q - LEVEL_W'(1);
        default: level_d = level_q;
      endcase
      valid_d = (level_d != '0);
      // Next head is the incoming word when it lands in the slot being read.
      if (valid_d) begin
        head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = valid_q;
  assign level      = level_q;

endmodule

// File: rtl/bit_capture_buffer.sv
// Samples an async serial bit on edges of an async divided tick, packs MSB-first words into a FIFO.
// Optional word comparator enabled by defining CAPTURE_MATCH_EN.
module bit_capture_buffer
  import bit_capture_buffer_pkg::*;
#(
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter bit          SAMPLE_FALL = SAMPLE_FALL_DEF
`ifdef CAPTURE_MATCH_EN
  ,
  parameter logic [WORD_W-1:0] MATCH_WORD = WORD_W'(MATCH_WORD_DEF)
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick_in,
  input  logic                        bit_in,
  input  logic                        flush,
  input  logic                        ovf_clr,
  bit_capture_buffer_if.master        bus,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic                        overflow,
  output logic                        match_pulse
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  logic [SYNC_STAGES-1:0] tick_sync_q, tick_sync_d;
  logic [SYNC_STAGES-1:0] bit_sync_q, bit_sync_d;
  logic                   tick_q, tick_d;
  logic [WORD_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   tick_s, bit_s;
  logic                   sample_c, last_c, push_c, pop_c, drop_c, full_c;
  logic [WORD_W-1:0]      word_c;
  logic [WORD_W-1:0]      fifo_data;
  logic                   fifo_valid;

  assign tick_s   = tick_sync_q[SYNC_STAGES-1];
  assign bit_s    = bit_sync_q[SYNC_STAGES-1];
  assign sample_c = SAMPLE_FALL ? (tick_q & ~tick_s) : (~tick_q & tick_s);
  assign word_c   = {shift_q[WORD_W-2:0], bit_s};
  assign last_c   = (cnt_q == CNT_W'(WORD_W - 1));
  assign push_c   = sample_c & last_c & ~flush;
  assign pop_c    = fifo_valid & bus.word_ready;
  assign drop_c   = push_c & full_c & ~pop_c;

  always_comb begin
    tick_sync_d = {tick_sync_q[SYNC_STAGES-2:0], tick_in};
    bit_sync_d  = {bit_sync_q[SYNC_STAGES-2:0], bit_in};
    tick_d      = tick_s;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    if (flush) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (sample_c) begin
      shift_d = word_c;
      cnt_d   = last_c ? '0 : CNT_W'(cnt_q + 1'b1);
    end
    // A drop in the clearing cycle must leave the flag set.
    if (ovf_clr) ovf_d = 1'b0;
    if (drop_c)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync_q <= '0;
      bit_sync_q  <= '0;
      tick_q      <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      tick_sync_q <= tick_sync_d;
      bit_sync_q  <= bit_sync_d;
      tick_q      <= tick_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef CAPTURE_MATCH_EN
  logic match_q, match_d;

  always_comb begin
    match_d = push_c & (word_c == MATCH_WORD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_q <= 1'b0;
    else        match_q <= match_d;
  end

  assign match_pulse = match_q;
`else
  assign match_pulse = 1'b0;
`endif

  bit_capture_buffer_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .push_data  (word_c),
    .pop        (bus.word_ready),
    .flush      (flush),
    .head_data  (fifo_data),
    .head_valid (fifo_valid),
    .full_c     (full_c),
    .level      (level)
  );

  assign bus.word_data  = fifo_data;
  assign bus.word_valid = fifo_valid;
  assign overflow       = ovf_q;

endmodule
